// File: rtl/mod_mult_seq_pkg.sv
// Shared types and constants for the sequential signed multiplier.
//   state_t   : controller state encoding
//   MODO_*    : result-mode encoding of the modo_sat input
package mod_mult_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODO_WRAP = 1'b0;
  localparam logic MODO_SAT  = 1'b1;

endpackage

// File: rtl/mod_mult_seq_if.sv
// Operand/result handshake bundle for mod_mult_seq.
//   in_valid/in_ready   : operand handshake (a, b, modo_sat)
//   out_valid/out_ready : result handshake (resultado, produto, flag_overflow)
//   slave  : the multiplier side
//   master : the producer/consumer side
interface mod_mult_seq_if #(
  parameter int unsigned W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             modo_sat;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     resultado;
  logic [2*W-1:0]   produto;
  logic             flag_overflow;

  modport slave (
    input  in_valid, a, b, modo_sat, out_ready,
    output in_ready, out_valid, resultado, produto, flag_overflow
  );

  modport master (
    output in_valid, a, b, modo_sat, out_ready,
    input  in_ready, out_valid, resultado, produto, flag_overflow
  );
endinterface

// File: rtl/mod_abs.sv
// Two's complement to unsigned magnitude.
//   x   : signed W-bit input
//   mag : |x| as W-bit unsigned; -2^(W-1) maps to 2^(W-1), which still fits
module mod_abs #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] mag
);
  assign mag = x[W-1] ? (~x + W'(1)) : x;
endmodule

// File: rtl/mod_mult_seq.sv
// Multi-cycle signed multiplier: radix-2 shift-add on magnitudes, one
// multiplier bit per cycle, sign applied when the result is registered.
//   clk, rst : clock, synchronous active-high reset
//   bus      : operand/result handshake (see mod_mult_seq_if)
// Latency: out_valid rises W+1 edges after acceptance (W add cycles plus
// one finalize cycle that applies sign, overflow and saturation).
module mod_mult_seq
  import mod_mult_seq_pkg::*;
#(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = $clog2(W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  mod_mult_seq_if.slave     bus
);

  localparam int unsigned PW = 2 * W;
  localparam logic [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   mcand;
  logic [W-1:0]    mplier;
  logic [PW-1:0]   acc;
  logic            sign_r;
  logic            sat_r;

  logic [W-1:0]    mag_a_c;
  logic [W-1:0]    mag_b_c;
  logic            sign_c;
  logic [PW-1:0]   acc_add_c;
  logic [PW-1:0]   prod_c;
  logic [W:0]      prod_hi_c;
  logic            ovf_c;
  logic [W-1:0]    res_c;

  mod_abs #(.W(W)) u_abs_a (.x(bus.a), .mag(mag_a_c));
  mod_abs #(.W(W)) u_abs_b (.x(bus.b), .mag(mag_b_c));

  // A zero operand forces a positive sign so zero never becomes negative.
  assign sign_c = (bus.a[W-1] ^ bus.b[W-1]) && (|bus.a) && (|bus.b);

  // Partial-product add, sign restore, overflow and saturation.
  always_comb begin
    acc_add_c = acc;
    if (mplier[0]) begin
      acc_add_c = acc + mcand;
    end
    prod_c    = sign_r ? (~acc + PW'(1)) : acc;
    // Fits in W signed bits iff the top W+1 bits are a pure sign extension.
    prod_hi_c = prod_c[PW-1:W-1];
    ovf_c     = !((&prod_hi_c) || !(|prod_hi_c));
    res_c     = prod_c[W-1:0];
    if (ovf_c && (sat_r == MODO_SAT)) begin
      res_c = sign_r ? SMIN : SMAX;
    end
  end

  // Controller, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= ST_IDLE;
      cnt               <= '0;
      mcand             <= '0;
      mplier            <= '0;
      acc               <= '0;
      sign_r            <= 1'b0;
      sat_r             <= MODO_WRAP;
      bus.in_ready      <= 1'b1;
      bus.out_valid     <= 1'b0;
      bus.resultado     <= '0;
      bus.produto       <= '0;
      bus.flag_overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid && bus.in_ready) begin
            mcand        <= {W'(0), mag_a_c};
            mplier       <= mag_b_c;
            acc          <= '0;
            cnt          <= '0;
            sign_r       <= sign_c;
            sat_r        <= bus.modo_sat;
            bus.in_ready <= 1'b0;
            state        <= ST_CALC;
          end
        end
        ST_CALC: begin
          // cnt 0..W-1 accumulate; cnt == W registers the final result.
          if (cnt == CW'(W)) begin
            bus.produto       <= prod_c;
            bus.flag_overflow <= ovf_c;
            bus.resultado     <= res_c;
            bus.out_valid     <= 1'b1;
            cnt               <= '0;
            state             <= ST_DONE;
          end else begin
            acc    <= acc_add_c;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_mult_seq.sv
// Directed self-checking bench for mod_mult_seq with W=8.
module tb_mod_mult_seq;

  localparam int unsigned W = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mod_mult_seq_if #(.W(W)) bus ();

  mod_mult_seq #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation and wait for out_valid; lat counts edges after the
  // acceptance edge. Operands are scrambled right after acceptance.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_op,
                       input logic sat, output int lat, output logic rdy_acc,
                       output logic [7:0] r, output logic [15:0] p,
                       output logic o);
    int w;
    w = 0;
    while (!bus.in_ready && w < 40) begin
      @(posedge clk); #1; w++;
    end
    bus.a        = ta;
    bus.b        = tb_op;
    bus.modo_sat = sat;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = ~ta;
    bus.b        = tb_op + 8'd37;
    bus.modo_sat = ~sat;
    rdy_acc      = bus.in_ready;
    lat = 0;
    while (!bus.out_valid && lat < 30) begin
      @(posedge clk); #1; lat++;
    end
    r = bus.resultado;
    p = bus.produto;
    o = bus.flag_overflow;
  endtask

  // Complete the output handshake (out_ready assumed high).
  task automatic drain();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = 8'h00;
    bus.b         = 8'h00;
    bus.modo_sat  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.resultado !== 8'h00 ||
        bus.produto !== 16'h0000 || bus.flag_overflow !== 1'b0) begin
      bad++;
      $display("FAIL reset: rdy=%b vld=%b res=%h prod=%h ovf=%b, want 1 0 00 0000 0",
               bus.in_ready, bus.out_valid, bus.resultado, bus.produto, bus.flag_overflow);
    end
  endtask

  task automatic test_basic();
    int lat; logic ra; logic [7:0] r; logic [15:0] p; logic o;
    do_op(8'd5, 8'd3, 1'b0, lat, ra, r, p, o);
    total++;
    if (lat !== 9) begin bad++; $display("FAIL latency_5x3: got %0d want 9", lat); end
    total++;
    if (ra !== 1'b0) begin bad++; $display("FAIL in_ready_drop: got %b want 0", ra); end
    total++;
    if (r !== 8'h0F || p !== 16'h000F || o !== 1'b0) begin
      bad++; $display("FAIL mul_5x3: res=%h prod=%h ovf=%b want 0f 000f 0", r, p, o);
    end
    drain();
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL return_idle: vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    do_op(8'd10, 8'hFE, 1'b0, lat, ra, r, p, o);
    total++;
    if (r !== 8'hEC || p !== 16'hFFEC || o !== 1'b0 || lat !== 9) begin
      bad++; $display("FAIL mul_10xm2: res=%h prod=%h ovf=%b lat=%0d want ec ffec 0 9", r, p, o, lat);
    end
    drain();
  endtask

  task automatic test_overflow();
    int lat; logic ra; logic [7:0] r; logic [15:0] p; logic o;
    do_op(8'd50, 8'd6, 1'b0, lat, ra, r, p, o);
    total++;
    if (r !== 8'h2C || p !== 16'h012C || o !== 1'b1) begin
      bad++; $display("FAIL ovf_50x6_wrap: res=%h prod=%h ovf=%b want 2c 012c 1", r, p, o);
    end
    drain();
    do_op(8'd50, 8'd6, 1'b1, lat, ra, r, p, o);
    total++;
    if (r !== 8'h7F || p !== 16'h012C || o !== 1'b1) begin
      bad++; $display("FAIL ovf_50x6_sat: res=%h prod=%h ovf=%b want 7f 012c 1", r, p, o);
    end
    drain();
    do_op(8'hBA, 8'd3, 1'b0, lat, ra, r, p, o);
    total++;
    if (r !== 8'h2E || p !== 16'hFF2E || o !== 1'b1) begin
      bad++; $display("FAIL ovf_m70x3_wrap: res=%h prod=%h ovf=%b want 2e ff2e 1", r, p, o);
    end
    drain();
    do_op(8'hBA, 8'd3, 1'b1, lat, ra, r, p, o);
    total++;
    if (r !== 8'h80 || p !== 16'hFF2E || o !== 1'b1) begin
      bad++; $display("FAIL ovf_m70x3_sat: res=%h prod=%h ovf=%b want 80 ff2e 1", r, p, o);
    end
    drain();
    do_op(8'hA6, 8'hFE, 1'b1, lat, ra, r, p, o);
    total++;
    if (r !== 8'h7F || p !== 16'h00B4 || o !== 1'b1) begin
      bad++; $display("FAIL ovf_m90xm2_sat: res=%h prod=%h ovf=%b want 7f 00b4 1", r, p, o);
    end
    drain();
  endtask

  task automatic test_boundary();
    int lat; logic ra; logic [7:0] r; logic [15:0] p; logic o;
    do_op(8'h80, 8'h80, 1'b0, lat, ra, r, p, o);
    total++;
    if (r !== 8'h00 || p !== 16'h4000 || o !== 1'b1) begin
      bad++; $display("FAIL min_x_min_wrap: res=%h prod=%h ovf=%b want 00 4000 1", r, p, o);
    end
    drain();
    do_op(8'h80, 8'h80, 1'b1, lat, ra, r, p, o);
    total++;
    if (r !== 8'h7F || p !== 16'h4000 || o !== 1'b1) begin
      bad++; $display("FAIL min_x_min_sat: res=%h prod=%h ovf=%b want 7f 4000 1", r, p, o);
    end
    drain();
    do_op(8'h80, 8'h01, 1'b1, lat, ra, r, p, o);
    total++;
    if (r !== 8'h80 || p !== 16'hFF80 || o !== 1'b0) begin
      bad++; $display("FAIL min_x_one: res=%h prod=%h ovf=%b want 80 ff80 0", r, p, o);
    end
    drain();
    do_op(8'h00, 8'd100, 1'b0, lat, ra, r, p, o);
    total++;
    if (r !== 8'h00 || p !== 16'h0000 || o !== 1'b0) begin
      bad++; $display("FAIL zero_x_100: res=%h prod=%h ovf=%b want 00 0000 0", r, p, o);
    end
    drain();
    do_op(8'hFB, 8'h00, 1'b1, lat, ra, r, p, o);
    total++;
    if (r !== 8'h00 || p !== 16'h0000 || o !== 1'b0) begin
      bad++; $display("FAIL m5_x_zero_sat: res=%h prod=%h ovf=%b want 00 0000 0", r, p, o);
    end
    drain();
  endtask

  task automatic test_back_pressure();
    int lat; logic ra; logic [7:0] r; logic [15:0] p; logic o;
    bus.out_ready = 1'b0;
    do_op(8'd7, 8'hFD, 1'b0, lat, ra, r, p, o);
    total++;
    if (r !== 8'hEB || p !== 16'hFFEB || o !== 1'b0 || lat !== 9) begin
      bad++; $display("FAIL bp_result: res=%h prod=%h ovf=%b lat=%0d want eb ffeb 0 9", r, p, o, lat);
    end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.a        = bus.a + 8'd3;
      bus.b        = bus.b - 8'd5;
      @(posedge clk); #1;
      total++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.resultado !== 8'hEB ||
          bus.produto !== 16'hFFEB || bus.flag_overflow !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold_%0d: vld=%b rdy=%b res=%h prod=%h ovf=%b want 1 0 eb ffeb 0",
                 i, bus.out_valid, bus.in_ready, bus.resultado, bus.produto, bus.flag_overflow);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_release: vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
    end
    repeat (3) @(posedge clk); #1;
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_no_second_accept: vld=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_abort();
    int lat; logic ra; logic [7:0] r; logic [15:0] p; logic o; int seen;
    bus.a        = 8'd9;
    bus.b        = 8'd9;
    bus.modo_sat = 1'b0;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.resultado !== 8'h00 ||
        bus.produto !== 16'h0000 || bus.flag_overflow !== 1'b0) begin
      bad++;
      $display("FAIL abort_state: rdy=%b vld=%b res=%h prod=%h ovf=%b want 1 0 00 0000 0",
               bus.in_ready, bus.out_valid, bus.resultado, bus.produto, bus.flag_overflow);
    end
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin bad++; $display("FAIL abort_no_output: valid cycles=%0d want 0", seen); end
    do_op(8'd7, 8'd7, 1'b0, lat, ra, r, p, o);
    total++;
    if (r !== 8'h31 || p !== 16'h0031 || o !== 1'b0 || lat !== 9) begin
      bad++; $display("FAIL after_abort_7x7: res=%h prod=%h ovf=%b lat=%0d want 31 0031 0 9", r, p, o, lat);
    end
    drain();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_boundary();
    test_back_pressure();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
